// File: rtl/haar_coef_serializer_if.sv
// Output stream of the Haar coefficient serializer: one tagged coefficient
// per transfer under valid/ready flow control.
//   outValid   - head entry valid (master -> slave)
//   outReady   - slave accepts the head this cycle (slave -> master)
//   outData    - signed coefficient at the head
//   outChannel - channel index of the head coefficient
interface haar_coef_serializer_if #(
    parameter int WIDTH    = 16,
    parameter int CH_WIDTH = 4
);
    logic                outValid;
    logic                outReady;
    logic [WIDTH-1:0]    outData;
    logic [CH_WIDTH-1:0] outChannel;

    modport master (output outValid, output outData, output outChannel, input outReady);
    modport slave  (input outValid, input outData, input outChannel, output outReady);
endinterface

// File: rtl/haar_coef_serializer.sv
// Collects the multirate outputs of the Haar analysis filter bank and emits
// them as a single tagged stream. Each channel has a one-deep holding
// register with a pending flag; a fixed-priority arbiter (lowest channel
// first) moves at most one pending coefficient per cycle into a show-ahead
// FIFO, whose head drives the output stream.
// Ports:
//   clk          - system clock, rising edge
//   rstN         - synchronous active-low reset
//   inStrobes    - per-channel new-sample strobes (channel 0 = final low-pass)
//   dataIn       - packed words, channel k at [WIDTH*k +: WIDTH]
//   out_if       - tagged output stream (master side)
//   fifoCount    - current FIFO occupancy
//   overflow     - sticky flag: a coefficient was overwritten before queuing
//   clrOverflow  - clears overflow (a same-cycle new loss keeps it set)
module haar_coef_serializer #(
    parameter int STAGES     = 4,
    parameter int WIDTH      = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int CH_WIDTH   = 4
) (
    input  logic                            clk,
    input  logic                            rstN,
    input  logic [STAGES:0]                 inStrobes,
    input  logic [WIDTH*(STAGES+1)-1:0]     dataIn,
    haar_coef_serializer_if.master          out_if,
    output logic [$clog2(FIFO_DEPTH):0]     fifoCount,
    output logic                            overflow,
    input  logic                            clrOverflow
);
    localparam int NCH     = STAGES + 1;
    localparam int ADDR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = ADDR_W + 1;
    localparam int ENTRY_W = CH_WIDTH + WIDTH;

    logic [WIDTH-1:0]   hold [NCH];
    logic [NCH-1:0]     pend;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]   count;

    logic                sel_found;
    logic [CH_WIDTH-1:0] sel_idx;
    logic [WIDTH-1:0]    sel_data;
    logic                push;
    logic                pop;
    logic [NCH-1:0]      push_mask;
    logic                ovf_set;

    // Fixed priority: scanning downwards leaves the lowest pending channel selected.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_data  = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (pend[k]) begin
                sel_found = 1'b1;
                sel_idx   = CH_WIDTH'(k);
                sel_data  = hold[k];
            end
        end
    end

    // Push decision uses the start-of-cycle count, so a full FIFO never
    // accepts a push even when it is popped in the same cycle.
    assign push      = sel_found && (count < CNT_W'(FIFO_DEPTH));
    assign pop       = out_if.outValid && out_if.outReady;
    assign push_mask = push ? (NCH'(1) << sel_idx) : '0;
    // A new strobe on a still-pending channel loses the older value, unless
    // that older value is being queued in this very cycle.
    assign ovf_set   = |(inStrobes & pend & ~push_mask);

    assign out_if.outValid   = (count != '0);
    assign out_if.outData    = mem[rd_ptr][WIDTH-1:0];
    assign out_if.outChannel = mem[rd_ptr][ENTRY_W-1:WIDTH];
    assign fifoCount         = count;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            pend     <= '0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            for (int k = 0; k < NCH; k++) begin
                hold[k] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (inStrobes[k]) begin
                    hold[k] <= dataIn[WIDTH*k +: WIDTH];
                    pend[k] <= 1'b1;
                end else if (push_mask[k]) begin
                    pend[k] <= 1'b0;
                end
            end

            if (push) begin
                mem[wr_ptr] <= {sel_idx, sel_data};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clrOverflow) begin
                overflow <= 1'b0;
            end
        end
    end
endmodule
